// File: rtl/nandy_pkg.sv
// Shared definitions for the register bank and its write-side logic.
package nandy_pkg;

  // Default widths, shared with the register bank itself.
  localparam int DW = 8;
  localparam int AW = 3;

  // Write sequencer state encoding. 2'd3 is unused and recovers to idle.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector. The search starts at the requester
// after `last` and wraps modulo NREQ. NREQ does not have to be a power of two.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int LW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] win,
  output logic            valid
);

  // Scan the offsets last+1 .. last+NREQ and keep the first active requester.
  always_comb begin
    win   = '0;
    valid = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!valid && req[i] && (i == (int'(last) + k) % NREQ)) begin
          win[i] = 1'b1;
          valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regbank_wr_arbiter.sv
// Round-robin write arbiter and two-phase write sequencer for the shared
// register bank.
// In SETUP, gnt is high and the address and data are presented to the bank.
// In STROBE, bank_we is high and the address and data do not change.
// Because of this, the bank's dff inputs are stable for a full cycle before
// the write enable rises.
module regbank_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = nandy_pkg::DW,
  parameter int AW   = nandy_pkg::AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic [AW-1:0]      bank_addr,
  output logic [DW-1:0]      bank_d,
  output logic               bank_we,
  output logic               busy
);
  import nandy_pkg::*;

  localparam int LW = $clog2(NREQ);

  state_e          state;
  logic [LW-1:0]   last;
  logic [NREQ-1:0] win;
  logic            win_vld;
  logic [LW-1:0]   widx;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  rr_pick #(.NREQ(NREQ), .LW(LW)) u_pick (
    .req   (req),
    .last  (last),
    .win   (win),
    .valid (win_vld)
  );

  // Turn the one-hot winner into an index and select the winner's address/data slice.
  always_comb begin
    widx     = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) begin
        widx     = LW'(i);
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // State, round-robin pointer and all outputs are registered. IDLE and
  // STROBE both arbitrate, which allows one write every two cycles when
  // requests keep coming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      bank_we   <= 1'b0;
      bank_addr <= '0;
      bank_d    <= '0;
      busy      <= 1'b0;
      last      <= LW'(NREQ - 1);
    end else begin
      case (state)
        ST_IDLE, ST_STROBE: begin
          bank_we <= 1'b0;
          if (win_vld) begin
            state     <= ST_SETUP;
            gnt       <= win;
            bank_addr <= sel_addr;
            bank_d    <= sel_data;
            busy      <= 1'b1;
            last      <= widx;
          end else begin
            state <= ST_IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
          end
        end
        ST_SETUP: begin
          // req is ignored in this state. The address and data were captured at the previous edge.
          state   <= ST_STROBE;
          gnt     <= '0;
          bank_we <= 1'b1;
          busy    <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          gnt     <= '0;
          bank_we <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Scoreboard bench for regbank_wr_arbiter.
// The model pushes one expected grant at each arbitration edge.
// The monitor pops an expected grant whenever gnt is seen, then checks the strobe cycle that follows.
module tb_regbank_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int AW   = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]    gnt;
  logic [AW-1:0]      bank_addr;
  logic [DW-1:0]      bank_d;
  logic               bank_we;
  logic               busy;

  always #5 clk = ~clk;

  regbank_wr_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .gnt       (gnt),
    .bank_addr (bank_addr),
    .bank_d    (bank_d),
    .bank_we   (bank_we),
    .busy      (busy)
  );

  typedef struct {
    int            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            cyc;
  } exp_t;

  exp_t            q[$];
  int              n_chk = 0;
  int              n_fail = 0;
  int              cyc = 0;
  int              rand_pct = 0;
  logic [NREQ-1:0] keep = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model. The arbiter is free at an edge unless it granted at the previous edge.
  // The winner is the first active requester scanning upward from last+1.
  initial begin : model
    int   hold;
    int   m_last;
    int   w;
    exp_t e;
    hold   = 0;
    m_last = NREQ - 1;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        hold   = 0;
        m_last = NREQ - 1;
        q.delete();
      end else begin
        cyc++;
        if (hold > 0) hold--;
        else if (req != '0) begin
          w = -1;
          for (int k = 1; k <= NREQ; k++)
            for (int i = 0; i < NREQ; i++)
              if (w < 0 && req[i] && i == (m_last + k) % NREQ) w = i;
          e.w = w;
          e.cyc = cyc;
          for (int i = 0; i < NREQ; i++)
            if (i == w) begin
              e.a = req_addr[i*AW +: AW];
              e.d = req_data[i*DW +: DW];
            end
          q.push_back(e);
          m_last = w;
          hold = 1;
        end
      end
    end
  end

  // Monitor, sampling on the falling edge.
  initial begin : monitor
    exp_t          pe;
    logic          pend;
    logic          had;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    pend = 1'b0;
    pa = '0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_we", 32'(bank_we), 0);
        check("rst_addr", 32'(bank_addr), 0);
        check("rst_d", 32'(bank_d), 0);
        check("rst_busy", 32'(busy), 0);
      end else begin
        check("gnt_onehot0", 32'($onehot0(gnt)), 1);
        check("gnt_we_excl", 32'((gnt != '0) && bank_we), 0);
        check("busy", 32'(busy), 32'((gnt != '0) || bank_we));
        had = pend;
        pend = 1'b0;
        if (bank_we) begin
          check("we_after_gnt", 32'(had), 1);
          if (had) begin
            check("bank_addr", 32'(bank_addr), 32'(pe.a));
            check("bank_d", 32'(bank_d), 32'(pe.d));
            check("addr_stable", 32'(bank_addr), 32'(pa));
            check("d_stable", 32'(bank_d), 32'(pd));
          end
        end else if (had) begin
          check("strobe_missing", 32'(bank_we), 1);
        end
        if (gnt != '0) begin
          if (q.size() == 0) check("gnt_unexpected", 32'(gnt), 0);
          else begin
            pe = q.pop_front();
            check("gnt_who", 32'(gnt), 32'(1 << pe.w));
            check("gnt_cycle", 32'(cyc), 32'(pe.cyc));
            pend = 1'b1;
          end
        end
      end
      pa = bank_addr;
      pd = bank_d;
    end
  end

  // Each requester deasserts req at the edge that ends its gnt cycle, unless it is persistent.
  // After a grant, it also scrambles its data.
  task automatic step();
    logic [NREQ-1:0] g;
    @(negedge clk);
    g = gnt;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (g[i]) begin
        if (!keep[i]) req[i] = 1'b0;
        req_addr[i*AW +: AW] = AW'($urandom);
        req_data[i*DW +: DW] = DW'($urandom);
      end
      if (!req[i] && rand_pct > 0 && int'($urandom_range(99)) < rand_pct) begin
        req[i] = 1'b1;
        req_addr[i*AW +: AW] = AW'($urandom);
        req_data[i*DW +: DW] = DW'($urandom);
      end
    end
  endtask

  task automatic set_rq(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    for (int j = 0; j < NREQ; j++)
      if (j == i) begin
        req[j] = 1'b1;
        req_addr[j*AW +: AW] = a;
        req_data[j*DW +: DW] = d;
      end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int exp_g[9];
    int exp_w[9];
    int exp_s[4];
    exp_g = '{1, 0, 2, 0, 4, 0, 8, 0, 1};
    exp_w = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
    exp_s = '{2, 0, 2, 0};

    repeat (2) @(posedge clk);
    #1;
    check("reset_gnt", 32'(gnt), 0);
    check("reset_we", 32'(bank_we), 0);
    check("reset_busy", 32'(busy), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();

    // Single request.
    set_rq(2, 3'd5, 8'hA5);
    step();
    check("single_gnt", 32'(gnt), 32'h4);
    check("single_we_low", 32'(bank_we), 0);
    step();
    check("single_gnt_off", 32'(gnt), 0);
    check("single_we", 32'(bank_we), 1);
    check("single_addr", 32'(bank_addr), 5);
    check("single_d", 32'(bank_d), 32'hA5);
    step();
    check("single_idle_we", 32'(bank_we), 0);
    check("single_idle_busy", 32'(busy), 0);

    // Requester changes data after gnt.
    set_rq(1, 3'd3, 8'h11);
    step();
    check("chg_gnt", 32'(gnt), 32'h2);
    step();
    req_data[1*DW +: DW] = 8'hFF;
    check("chg_we", 32'(bank_we), 1);
    check("chg_d_early", 32'(bank_d), 32'h11);
    #3;
    check("chg_d_late", 32'(bank_d), 32'h11);
    step();

    // Requesters 1 and 3, with last = 1.
    keep = 4'b1010;
    set_rq(1, 3'd1, 8'h21);
    set_rq(3, 3'd3, 8'h43);
    step();
    check("rr_3_first", 32'(gnt), 32'h8);
    step();
    step();
    check("rr_1_next", 32'(gnt), 32'h2);
    repeat (8) begin
      step();
      check("rr_never_0_2", 32'(gnt & 4'b0101), 0);
    end
    keep = '0;
    req = '0;
    repeat (3) step();

    // All four requesters request continuously, starting from reset priority.
    rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();
    keep = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_rq(i, AW'(i + 1), DW'(8'h30 + i));
    for (int s = 0; s < 9; s++) begin
      step();
      check("all4_gnt", 32'(gnt), 32'(exp_g[s]));
      check("all4_we", 32'(bank_we), 32'(exp_w[s]));
    end
    keep = '0;
    req = '0;
    repeat (3) step();

    // A single persistent requester is granted every 2 cycles.
    keep = 4'b0010;
    set_rq(1, 3'd6, 8'h66);
    for (int s = 0; s < 4; s++) begin
      step();
      check("persist_gnt", 32'(gnt), 32'(exp_s[s]));
    end
    keep = '0;
    req = '0;
    repeat (3) step();

    // Reset during STROBE.
    set_rq(2, 3'd6, 8'h3C);
    step();
    step();
    check("pre_rst_we", 32'(bank_we), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_we", 32'(bank_we), 0);
    check("rst_mid_gnt", 32'(gnt), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_addr", 32'(bank_addr), 0);
    check("rst_mid_d", 32'(bank_d), 0);
    req = '0;
    set_rq(0, 3'd1, 8'h5A);
    set_rq(3, 3'd7, 8'hC3);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("after_rst_gnt", 32'(gnt), 32'h1);
    repeat (6) step();

    // Randomized load, with invariants checked by the monitor.
    rand_pct = 40;
    for (int s = 0; s < 1000; s++) begin
      if (s % 100 == 50) keep = NREQ'($urandom);
      if (s % 100 == 0) keep = '0;
      step();
    end
    rand_pct = 0;
    keep = '0;
    req = '0;
    repeat (4) step();
    check("queue_drained", 32'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
